// File: rtl/dbus_mem_responder.sv
// Data-bus target backed by a word-addressed RAM with a fixed response latency.
// One request in flight at a time; response data, handshakes and error flags are register/state driven.
module dbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        err_range,
  output logic        err_align,
  output logic        err_proto
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic            r_oor;
  logic            r_mis;
  logic [7:0]      r_strobe;
  logic [63:0]     r_wdata;
  logic            r_err_range;
  logic            r_err_align;
  logic            r_err_proto;
  logic [63:0]     r_mem [MEM_WORDS];

  logic [63:0]     w_req_off;
  logic            w_req_oor;
  logic            w_req_mis;
  logic            w_resp;

  // Window offset; negative addresses wrap to huge offsets and fall out of range.
  assign w_req_off = dreq_addr - BASE_ADDR;
  assign w_req_oor = (w_req_off >= (64'(MEM_WORDS) * 64'd8));

  always_comb begin
    w_req_mis = 1'b0;
    case (dreq_size)
      3'd1:    w_req_mis = dreq_addr[0];
      3'd2:    w_req_mis = |dreq_addr[1:0];
      3'd3:    w_req_mis = |dreq_addr[2:0];
      default: w_req_mis = 1'b0;
    endcase
  end

  // Transaction sequencer; sticky errors are raised as the response cycle begins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_oor       <= 1'b0;
      r_mis       <= 1'b0;
      r_strobe    <= '0;
      r_wdata     <= '0;
      r_err_range <= 1'b0;
      r_err_align <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dreq_valid) begin
            r_idx    <= w_req_off[AW+2:3];
            r_oor    <= w_req_oor;
            r_mis    <= w_req_mis;
            r_strobe <= dreq_strobe;
            r_wdata  <= dreq_data;
            r_cnt    <= CW'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_err_range <= r_err_range | w_req_oor;
              r_err_align <= r_err_align | w_req_mis;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (!dreq_valid) r_err_proto <= 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state     <= S_RESP;
            r_err_range <= r_err_range | r_oor;
            r_err_align <= r_err_align | r_mis;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane write at the close of the response cycle; RAM survives reset.
  always_ff @(posedge clk) begin
    if (reset && (r_state == S_RESP) && !r_oor) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign w_resp        = (r_state == S_RESP);
  assign dresp_addr_ok = w_resp;
  assign dresp_data_ok = w_resp;
  assign dresp_data    = (w_resp && !r_oor) ? r_mem[r_idx] : 64'd0;
  assign err_range     = r_err_range;
  assign err_align     = r_err_align;
  assign err_proto     = r_err_proto;

endmodule
